// File: rtl/aes_ctr_incr_fsm.sv
// aes_ctr_incr_fsm: iterative slice-wise counter incrementer for AES CTR/GCM counters.
// Adds a zero-extended step to slice 0 and ripples the carry through one slice per cycle,
// across either all NumSlices slices (full mode) or only the LowSlices low slices (low mode).
// Optional feature macro: AES_CTR_WRAP_DET_EN enables ctr_wrap_o; otherwise it is tied low.
module aes_ctr_incr_fsm #(
  parameter int unsigned SliceSize = 16,
  parameter int unsigned NumSlices = 8,
  parameter int unsigned LowSlices = 2,
  localparam int unsigned SliceIdxW = $clog2(NumSlices)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 incr_i,
  input  logic                 mode_i,
  input  logic [SliceSize-1:0] step_i,
  output logic                 ready_o,
  output logic                 done_o,
  input  logic                 incr_err_i,
  input  logic                 mr_err_i,
  output logic                 alert_o,
  output logic [SliceIdxW-1:0] ctr_slice_idx_o,
  input  logic [SliceSize-1:0] ctr_slice_i,
  output logic [SliceSize-1:0] ctr_slice_o,
  output logic                 ctr_we_o,
  output logic                 ctr_wrap_o
);

  // Sparse encoding: every pair of states differs in at least three bits.
  typedef enum logic [4:0] {
    StIdle  = 5'b01001,
    StIncr  = 5'b10100,
    StError = 5'b11111
  } state_e;

  localparam logic [SliceIdxW-1:0] LastFull = SliceIdxW'(NumSlices - 1);
  localparam logic [SliceIdxW-1:0] LastLow  = SliceIdxW'(LowSlices - 1);

  // Raw vector so that any corrupted value is representable and caught by the default arm.
  logic [4:0]           state_d, state_q;
  logic [SliceIdxW-1:0] idx_d, idx_q;
  logic                 carry_d, carry_q;
  logic [SliceSize-1:0] step_d, step_q;
  logic                 mode_d, mode_q;

  logic [SliceIdxW-1:0] last_idx;
  logic [SliceSize-1:0] addend;
  logic [SliceSize:0]   sum;
  logic                 err;

  assign err      = incr_err_i | mr_err_i;
  // Last active slice follows from the mode latched with the request.
  assign last_idx = mode_q ? LastLow : LastFull;

  assign ctr_slice_idx_o = idx_q;

  // Slice adder: step enters at slice 0, the stored carry at every later slice.
  always_comb begin
    addend = (idx_q == '0) ? step_q : {{(SliceSize - 1){1'b0}}, carry_q};
    sum    = {1'b0, ctr_slice_i} + {1'b0, addend};
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    step_d      = step_q;
    mode_d      = mode_q;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    ctr_we_o    = 1'b0;
    alert_o     = 1'b0;
    ctr_slice_o = '0;

    case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (incr_i && !err) begin
          idx_d   = '0;
          carry_d = 1'b0;
          mode_d  = mode_i;
          step_d  = step_i;
          state_d = StIncr;
        end
      end
      StIncr: begin
        // Every active slice is written, carry or not, so latency is data independent.
        ctr_we_o    = 1'b1;
        ctr_slice_o = sum[SliceSize-1:0];
        carry_d     = sum[SliceSize];
        idx_d       = idx_q + 1'b1;
        if (idx_q == last_idx) begin
          done_o  = 1'b1;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StIdle;
        end
      end
      StError: begin
        alert_o = 1'b1;
      end
      default: begin
        alert_o = 1'b1;
        state_d = StError;
      end
    endcase

    // Integrity errors override everything, including an acceptance in the same cycle.
    if (err) begin
      state_d  = StError;
      ctr_we_o = 1'b0;
      done_o   = 1'b0;
    end
  end

`ifdef AES_CTR_WRAP_DET_EN
  // Wrap is the carry out of the final slice, reported alongside done_o.
  always_comb begin
    ctr_wrap_o = done_o & sum[SliceSize];
  end
`else
  // Wrap detection compiled out.
  always_comb begin
    ctr_wrap_o = 1'b0;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

endmodule
